// File: rtl/core_bus_pkg.sv
// Shared types and helpers for the core-to-Wishbone bridge: FSM states,
// request size encodings, byte-mask and alignment checks.
package core_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS   = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off,
                                         input int dw);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return off[1:0] != 2'b00;
      default: return (dw == 32) || (off != 3'b000);
    endcase
  endfunction

endpackage

// File: rtl/core_wb_lane_align.sv
// Combinational byte-lane steering: lane select, store-data replication and
// load-data alignment with sign/zero extension.
module core_wb_lane_align
  import core_bus_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = DATA_WIDTH / 8,
  parameter int OFF_W      = $clog2(SEL_WIDTH)
) (
  input  logic [1:0]            size,
  input  logic [OFF_W-1:0]      off,
  input  logic                  unsigned_ld,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic [SEL_WIDTH-1:0]  sel,
  output logic [DATA_WIDTH-1:0] st_lanes,
  output logic [DATA_WIDTH-1:0] ld_aligned
);

  logic [DATA_WIDTH-1:0] shifted;
  logic [7:0]            mask8;

  always_comb begin
    mask8   = size_mask(size) << off;
    sel     = SEL_WIDTH'(mask8);
    shifted = ld_data >> {off, 3'b000};

    case (size)
      SZ_B:    st_lanes = {SEL_WIDTH{st_data[7:0]}};
      SZ_H:    st_lanes = {(SEL_WIDTH / 2){st_data[15:0]}};
      SZ_W:    st_lanes = {(SEL_WIDTH / 4){st_data[31:0]}};
      default: st_lanes = st_data;
    endcase

    // Signed casts perform the sign extension; unsigned casts zero-fill.
    case (size)
      SZ_B: ld_aligned = unsigned_ld ? DATA_WIDTH'(shifted[7:0])
                                     : DATA_WIDTH'($signed(shifted[7:0]));
      SZ_H: ld_aligned = unsigned_ld ? DATA_WIDTH'(shifted[15:0])
                                     : DATA_WIDTH'($signed(shifted[15:0]));
      SZ_W: ld_aligned = unsigned_ld ? DATA_WIDTH'(shifted[31:0])
                                     : DATA_WIDTH'($signed(shifted[31:0]));
      default: ld_aligned = shifted;
    endcase
  end

endmodule

// File: rtl/core_wb_bridge.sv
// Single-outstanding bridge from a core valid/ready load/store port to a
// classic Wishbone B4 master, with lane steering, timeout and optional ack register.
module core_wb_bridge
  import core_bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ACK_REG        = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_core,
  input  logic                    rst_core,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [1:0]              req_size,
  input  logic                    req_unsigned,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  output logic                    rsp_err,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int OFF_W     = $clog2(SEL_WIDTH);
  localparam int TW        = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic                  lwe_q, lwe_d, uns_q, uns_d, err_q, err_d;
  logic [1:0]            size_q, size_d;
  logic [OFF_W-1:0]      off_q, off_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  cyc_q, cyc_d, stb_q, stb_d, wbwe_q, wbwe_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
  logic [TW-1:0]         cnt_q, cnt_d;
  logic                  ack_r_q, ack_r_d, err_r_q, err_r_d;
  logic [DATA_WIDTH-1:0] dat_r_q, dat_r_d;
  logic                  rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [1:0]            a_size;
  logic [OFF_W-1:0]      a_off;
  logic [SEL_WIDTH-1:0]  a_sel;
  logic [DATA_WIDTH-1:0] a_st_lanes, a_ld_aligned;
  logic                  ack_eff, err_eff, timeout_hit;

  // In IDLE the lane logic steers the incoming request; afterwards the latched one.
  assign a_size = (state_q == IDLE) ? req_size : size_q;
  assign a_off  = (state_q == IDLE) ? req_addr[OFF_W-1:0] : off_q;

  core_wb_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .size        (a_size),
    .off         (a_off),
    .unsigned_ld (uns_q),
    .st_data     (req_wdata),
    .ld_data     (rdata_q),
    .sel         (a_sel),
    .st_lanes    (a_st_lanes),
    .ld_aligned  (a_ld_aligned)
  );

  always_comb begin
    state_d = state_q;  lwe_d = lwe_q;  uns_d = uns_q;  err_d = err_q;
    size_d  = size_q;   off_d = off_q;  rdata_d = rdata_q;
    cyc_d   = cyc_q;    stb_d = stb_q;  wbwe_d = wbwe_q;
    sel_d   = sel_q;    adr_d = adr_q;  wdat_d = wdat_q;  cnt_d = cnt_q;
    rsp_valid_d = 1'b0; rsp_err_d = 1'b0; rsp_rdata_d = '0;
    ack_r_d = wb_ack_i & cyc_q;
    err_r_d = wb_err_i & cyc_q;
    dat_r_d = wb_dat_i;

    ack_eff     = (ACK_REG != 0) ? ack_r_q : wb_ack_i;
    err_eff     = (ACK_REG != 0) ? err_r_q : wb_err_i;
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TMO_LAST);

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          lwe_d  = req_we;
          uns_d  = req_unsigned;
          size_d = req_size;
          off_d  = req_addr[OFF_W-1:0];
          if (is_misaligned(req_size, req_addr[2:0], DATA_WIDTH)) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            wbwe_d  = req_we;
            sel_d   = a_sel;
            adr_d   = {req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
            wdat_d  = req_we ? a_st_lanes : '0;
            cnt_d   = '0;
            state_d = BUS;
          end
        end
      end
      BUS: begin
        cnt_d = cnt_q + 1'b1;
        if (ack_eff || err_eff || timeout_hit) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          wbwe_d  = 1'b0;
          sel_d   = '0;
          err_d   = err_eff | timeout_hit;
          rdata_d = (ACK_REG != 0) ? dat_r_q : wb_dat_i;
          state_d = (ACK_REG != 0) ? DRAIN : RESP;
        end
      end
      DRAIN: state_d = RESP;
      RESP: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = err_q;
        rsp_rdata_d = (err_q || lwe_q) ? '0 : a_ld_aligned;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      state_q <= IDLE;  lwe_q <= 1'b0;  uns_q <= 1'b0;  err_q <= 1'b0;
      size_q  <= SZ_B;  off_q <= '0;    rdata_q <= '0;
      cyc_q   <= 1'b0;  stb_q <= 1'b0;  wbwe_q <= 1'b0;
      sel_q   <= '0;    adr_q <= '0;    wdat_q <= '0;   cnt_q <= '0;
      ack_r_q <= 1'b0;  err_r_q <= 1'b0; dat_r_q <= '0;
      rsp_valid_q <= 1'b0; rsp_err_q <= 1'b0; rsp_rdata_q <= '0;
    end else begin
      state_q <= state_d;  lwe_q <= lwe_d;  uns_q <= uns_d;  err_q <= err_d;
      size_q  <= size_d;   off_q <= off_d;  rdata_q <= rdata_d;
      cyc_q   <= cyc_d;    stb_q <= stb_d;  wbwe_q <= wbwe_d;
      sel_q   <= sel_d;    adr_q <= adr_d;  wdat_q <= wdat_d;  cnt_q <= cnt_d;
      ack_r_q <= ack_r_d;  err_r_q <= err_r_d; dat_r_q <= dat_r_d;
      rsp_valid_q <= rsp_valid_d; rsp_err_q <= rsp_err_d; rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = stb_q;
  assign wb_we_o   = wbwe_q;
  assign wb_sel_o  = sel_q;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = wdat_q;

endmodule

// File: tb/tb_core_wb_bridge.sv
// Directed bench for core_wb_bridge: a plain bridge and a registered-ack bridge,
// each driven by a small Wishbone slave model with programmable wait/err/hold.
module tb_core_wb_bridge;
  import core_bus_pkg::*;

  logic clk, rst0, rst1;
  logic rv0, rv1, req_we, req_uns;
  logic [1:0] req_size;
  logic [31:0] req_addr, req_wdata, s_rdata;

  logic rdy0, rsp_v0, rsp_e0, cyc0, stb0, we0, ack0, err0;
  logic rdy1, rsp_v1, rsp_e1, cyc1, stb1, we1, ack1, err1;
  logic [31:0] rsp_d0, adr0, dato0, rsp_d1, adr1, dato1;
  logic [3:0] sel0, sel1;

  int s_waits, s_hold, w0, w1;
  logic s_ack_en, s_err_en;
  logic sel_dut;

  int nchk, nfail;
  int r_lat, r_cyc_n, r_pulses;
  logic r_err, r_we, r_ready1;
  logic [31:0] r_rdata, r_adr, r_dat;
  logic [3:0] r_sel;

  core_wb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ACK_REG(0), .TIMEOUT_CYCLES(8)) dut0 (
    .clk_core(clk), .rst_core(rst0), .req_valid(rv0), .req_ready(rdy0), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_uns), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_v0), .rsp_err(rsp_e0), .rsp_rdata(rsp_d0), .wb_cyc_o(cyc0), .wb_stb_o(stb0),
    .wb_we_o(we0), .wb_sel_o(sel0), .wb_adr_o(adr0), .wb_dat_o(dato0), .wb_dat_i(s_rdata),
    .wb_ack_i(ack0), .wb_err_i(err0));

  core_wb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ACK_REG(1), .TIMEOUT_CYCLES(8)) dut1 (
    .clk_core(clk), .rst_core(rst1), .req_valid(rv1), .req_ready(rdy1), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_uns), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_v1), .rsp_err(rsp_e1), .rsp_rdata(rsp_d1), .wb_cyc_o(cyc1), .wb_stb_o(stb1),
    .wb_we_o(we1), .wb_sel_o(sel1), .wb_adr_o(adr1), .wb_dat_o(dato1), .wb_dat_i(s_rdata),
    .wb_ack_i(ack1), .wb_err_i(err1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave models: w counts cycles cyc has been high; termination after s_waits cycles.
  always @(posedge clk) w0 <= cyc0 ? w0 + 1 : 0;
  always @(posedge clk) w1 <= cyc1 ? w1 + 1 : 0;
  assign ack0 = cyc0 & stb0 & s_ack_en & (w0 == s_waits);
  assign err0 = cyc0 & stb0 & s_err_en & (w0 == s_waits);
  assign ack1 = cyc1 & stb1 & s_ack_en & (w1 >= s_waits) & (w1 < s_waits + s_hold);
  assign err1 = 1'b0;

  wire       m_cyc   = sel_dut ? cyc1   : cyc0;
  wire       m_rv    = sel_dut ? rsp_v1 : rsp_v0;
  wire       m_re    = sel_dut ? rsp_e1 : rsp_e0;
  wire       m_rdy   = sel_dut ? rdy1   : rdy0;
  wire       m_we    = sel_dut ? we1    : we0;
  wire [31:0] m_rd   = sel_dut ? rsp_d1 : rsp_d0;
  wire [31:0] m_adr  = sel_dut ? adr1   : adr0;
  wire [31:0] m_dat  = sel_dut ? dato1  : dato0;
  wire [3:0]  m_sel  = sel_dut ? sel1   : sel0;

  // Issue one request and record latency (negedges after the accept edge),
  // first-cycle bus signals, cyc-high cycles and response pulses.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_we = we; req_size = size; req_uns = uns; req_addr = addr; req_wdata = wdata;
    if (sel_dut) rv1 = 1'b1; else rv0 = 1'b1;
    @(posedge clk);
    #1 rv0 = 1'b0; rv1 = 1'b0;
    r_lat = 0; r_cyc_n = 0; r_pulses = 0; r_err = 1'bx; r_rdata = 'x;
    r_sel = '0; r_adr = '0; r_dat = '0; r_we = 1'b0; r_ready1 = 1'bx;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) r_ready1 = m_rdy;
      if (m_cyc) begin
        if (r_cyc_n == 0) begin r_sel = m_sel; r_adr = m_adr; r_dat = m_dat; r_we = m_we; end
        r_cyc_n++;
      end
      if (m_rv) begin r_lat = k; r_err = m_re; r_rdata = m_rd; r_pulses = 1; break; end
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (m_rv) r_pulses++;
      if (m_cyc) r_cyc_n++;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    nchk++; if (rdy0 !== 1'b1) begin nfail++; $display("FAIL reset_ready0: got %b want 1", rdy0); end
    nchk++; if (rdy1 !== 1'b1) begin nfail++; $display("FAIL reset_ready1: got %b want 1", rdy1); end
    nchk++; if ({cyc0, stb0, we0, rsp_v0, rsp_e0} !== 5'b0) begin nfail++;
      $display("FAIL reset_ctrl0: got %b want 00000", {cyc0, stb0, we0, rsp_v0, rsp_e0}); end
    nchk++; if ({sel0, adr0, dato0, rsp_d0} !== 100'b0) begin nfail++;
      $display("FAIL reset_data0: sel %h adr %h dat %h rd %h want all 0", sel0, adr0, dato0, rsp_d0); end
  endtask

  task automatic test_word_load;
    sel_dut = 0; s_ack_en = 1; s_err_en = 0; s_waits = 0; s_rdata = 32'hDEADBEEF;
    do_req(1'b0, SZ_W, 1'b0, 32'h100, 32'h0);
    nchk++; if (r_sel !== 4'hF) begin nfail++; $display("FAIL word_sel: got %h want f", r_sel); end
    nchk++; if (r_adr !== 32'h100) begin nfail++; $display("FAIL word_adr: got %h want 100", r_adr); end
    nchk++; if (r_we !== 1'b0) begin nfail++; $display("FAIL word_we: got %b want 0", r_we); end
    nchk++; if (r_ready1 !== 1'b0) begin nfail++; $display("FAIL word_busy: ready %b want 0", r_ready1); end
    nchk++; if (r_lat !== 3) begin nfail++; $display("FAIL word_lat: got %0d want 3", r_lat); end
    nchk++; if (r_rdata !== 32'hDEADBEEF) begin nfail++; $display("FAIL word_rdata: got %h want deadbeef", r_rdata); end
    nchk++; if (r_err !== 1'b0) begin nfail++; $display("FAIL word_err: got %b want 0", r_err); end
    nchk++; if (r_cyc_n !== 1 || r_pulses !== 1) begin nfail++;
      $display("FAIL word_counts: cyc %0d rsp %0d want 1 1", r_cyc_n, r_pulses); end
  endtask

  task automatic test_byte_half_load;
    sel_dut = 0; s_ack_en = 1; s_err_en = 0; s_waits = 0; s_rdata = 32'h80FF1234;
    do_req(1'b0, SZ_B, 1'b0, 32'h103, 32'h0);
    nchk++; if (r_sel !== 4'b1000) begin nfail++; $display("FAIL sbyte_sel: got %b want 1000", r_sel); end
    nchk++; if (r_adr !== 32'h100) begin nfail++; $display("FAIL sbyte_adr: got %h want 100", r_adr); end
    nchk++; if (r_rdata !== 32'hFFFFFF80) begin nfail++; $display("FAIL sbyte_rdata: got %h want ffffff80", r_rdata); end
    do_req(1'b0, SZ_B, 1'b1, 32'h103, 32'h0);
    nchk++; if (r_rdata !== 32'h00000080) begin nfail++; $display("FAIL ubyte_rdata: got %h want 00000080", r_rdata); end
    s_rdata = 32'h8001_7F00;
    do_req(1'b0, SZ_H, 1'b0, 32'h202, 32'h0);
    nchk++; if (r_sel !== 4'b1100) begin nfail++; $display("FAIL shalf_sel: got %b want 1100", r_sel); end
    nchk++; if (r_rdata !== 32'hFFFF8001) begin nfail++; $display("FAIL shalf_rdata: got %h want ffff8001", r_rdata); end
    do_req(1'b0, SZ_B, 1'b0, 32'h201, 32'h0);
    nchk++; if (r_rdata !== 32'h0000007F) begin nfail++; $display("FAIL pbyte_rdata: got %h want 0000007f", r_rdata); end
  endtask

  task automatic test_stores;
    sel_dut = 0; s_ack_en = 1; s_err_en = 0; s_waits = 3; s_rdata = 32'hFFFFFFFF;
    do_req(1'b1, SZ_H, 1'b0, 32'h202, 32'h1234A5A5);
    nchk++; if (r_sel !== 4'b1100) begin nfail++; $display("FAIL hst_sel: got %b want 1100", r_sel); end
    nchk++; if (r_dat !== 32'hA5A5A5A5) begin nfail++; $display("FAIL hst_dat: got %h want a5a5a5a5", r_dat); end
    nchk++; if (r_we !== 1'b1) begin nfail++; $display("FAIL hst_we: got %b want 1", r_we); end
    nchk++; if (r_cyc_n !== 4) begin nfail++; $display("FAIL hst_stb_len: got %0d want 4", r_cyc_n); end
    nchk++; if (r_lat !== 6 || r_pulses !== 1) begin nfail++;
      $display("FAIL hst_rsp: lat %0d pulses %0d want 6 1", r_lat, r_pulses); end
    nchk++; if (r_err !== 1'b0 || r_rdata !== 32'h0) begin nfail++;
      $display("FAIL hst_result: err %b rdata %h want 0 0", r_err, r_rdata); end
    s_waits = 0;
    do_req(1'b1, SZ_B, 1'b0, 32'h301, 32'hCCCC005A);
    nchk++; if (r_sel !== 4'b0010 || r_dat !== 32'h5A5A5A5A) begin nfail++;
      $display("FAIL bst_lanes: sel %b dat %h want 0010 5a5a5a5a", r_sel, r_dat); end
  endtask

  task automatic test_misaligned;
    sel_dut = 0; s_ack_en = 1; s_err_en = 0; s_waits = 0; s_rdata = 32'h11111111;
    do_req(1'b0, SZ_W, 1'b0, 32'h101, 32'h0);
    nchk++; if (r_cyc_n !== 0) begin nfail++; $display("FAIL mis_w_cyc: got %0d cycles want 0", r_cyc_n); end
    nchk++; if (r_lat !== 2 || r_err !== 1'b1 || r_rdata !== 32'h0) begin nfail++;
      $display("FAIL mis_w_rsp: lat %0d err %b rd %h want 2 1 0", r_lat, r_err, r_rdata); end
    do_req(1'b1, SZ_H, 1'b0, 32'h201, 32'h0);
    nchk++; if (r_cyc_n !== 0 || r_err !== 1'b1) begin nfail++;
      $display("FAIL mis_h: cyc %0d err %b want 0 1", r_cyc_n, r_err); end
    do_req(1'b0, SZ_D, 1'b0, 32'h200, 32'h0);
    nchk++; if (r_cyc_n !== 0 || r_err !== 1'b1) begin nfail++;
      $display("FAIL mis_d32: cyc %0d err %b want 0 1", r_cyc_n, r_err); end
  endtask

  task automatic test_bus_error;
    sel_dut = 0; s_ack_en = 1; s_err_en = 1; s_waits = 1; s_rdata = 32'h55555555;
    do_req(1'b0, SZ_W, 1'b0, 32'h400, 32'h0);
    nchk++; if (r_err !== 1'b1 || r_rdata !== 32'h0) begin nfail++;
      $display("FAIL buserr_rsp: err %b rd %h want 1 0", r_err, r_rdata); end
    nchk++; if (r_cyc_n !== 2 || r_lat !== 4) begin nfail++;
      $display("FAIL buserr_timing: cyc %0d lat %0d want 2 4", r_cyc_n, r_lat); end
    s_err_en = 0;
  endtask

  task automatic test_timeout;
    sel_dut = 0; s_ack_en = 0; s_err_en = 0; s_waits = 0; s_rdata = 32'h77777777;
    do_req(1'b0, SZ_W, 1'b0, 32'h500, 32'h0);
    nchk++; if (r_cyc_n !== 8) begin nfail++; $display("FAIL tmo_cyc: got %0d cycles want 8", r_cyc_n); end
    nchk++; if (r_err !== 1'b1 || r_rdata !== 32'h0 || r_lat !== 10) begin nfail++;
      $display("FAIL tmo_rsp: err %b rd %h lat %0d want 1 0 10", r_err, r_rdata, r_lat); end
    s_ack_en = 1; s_rdata = 32'hCAFEF00D;
    do_req(1'b0, SZ_W, 1'b0, 32'h504, 32'h0);
    nchk++; if (r_err !== 1'b0 || r_rdata !== 32'hCAFEF00D || r_lat !== 3) begin nfail++;
      $display("FAIL tmo_next: err %b rd %h lat %0d want 0 cafef00d 3", r_err, r_rdata, r_lat); end
  endtask

  task automatic test_ack_reg;
    sel_dut = 1; s_ack_en = 1; s_waits = 0; s_hold = 2; s_rdata = 32'h12345678;
    do_req(1'b0, SZ_W, 1'b0, 32'h40, 32'h0);
    nchk++; if (r_pulses !== 1) begin nfail++; $display("FAIL ackreg_pulses: got %0d want 1", r_pulses); end
    nchk++; if (r_lat !== 5) begin nfail++; $display("FAIL ackreg_lat: got %0d want 5", r_lat); end
    nchk++; if (r_rdata !== 32'h12345678 || r_err !== 1'b0) begin nfail++;
      $display("FAIL ackreg_rsp: rd %h err %b want 12345678 0", r_rdata, r_err); end
    nchk++; if (r_cyc_n !== 2) begin nfail++; $display("FAIL ackreg_cyc: got %0d want 2", r_cyc_n); end
    s_hold = 1;
  endtask

  task automatic test_reset_in_bus;
    int seen;
    sel_dut = 1; s_ack_en = 0; s_hold = 1; s_rdata = 32'h0;
    @(negedge clk);
    req_we = 1'b0; req_size = SZ_W; req_uns = 1'b0; req_addr = 32'h80; rv1 = 1'b1;
    @(posedge clk);
    #1 rv1 = 1'b0;
    @(negedge clk);
    nchk++; if (cyc1 !== 1'b1) begin nfail++; $display("FAIL rstbus_pre: cyc %b want 1", cyc1); end
    #2 rst1 = 1'b1;
    #1;
    nchk++; if (cyc1 !== 1'b0 || stb1 !== 1'b0 || rdy1 !== 1'b1) begin nfail++;
      $display("FAIL rstbus_async: cyc %b stb %b ready %b want 0 0 1", cyc1, stb1, rdy1); end
    @(negedge clk) rst1 = 1'b0;
    seen = 0;
    for (int k = 0; k < 15; k++) begin @(negedge clk); if (rsp_v1 || cyc1) seen++; end
    nchk++; if (seen !== 0) begin nfail++; $display("FAIL rstbus_norsp: %0d busy cycles want 0", seen); end
    s_ack_en = 1; s_rdata = 32'h0BADF00D;
    do_req(1'b0, SZ_W, 1'b0, 32'h84, 32'h0);
    nchk++; if (r_rdata !== 32'h0BADF00D || r_lat !== 5) begin nfail++;
      $display("FAIL rstbus_after: rd %h lat %0d want 0badf00d 5", r_rdata, r_lat); end
  endtask

  initial begin
    nchk = 0; nfail = 0; sel_dut = 0;
    rv0 = 0; rv1 = 0; req_we = 0; req_size = SZ_B; req_uns = 0; req_addr = '0; req_wdata = '0;
    s_waits = 0; s_hold = 1; s_ack_en = 0; s_err_en = 0; s_rdata = '0;
    rst0 = 1; rst1 = 1;
    repeat (3) @(negedge clk);
    rst0 = 0; rst1 = 0;
    test_reset;
    test_word_load;
    test_byte_half_load;
    test_stores;
    test_misaligned;
    test_bus_error;
    test_timeout;
    test_ack_reg;
    test_reset_in_bus;
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
